memory_arbiter: RTL

Single-port memory arbiter. It is the responder side of the request unit's `imemREN`/`dmemREN`/`dmemWEN` handshake. It accepts one instruction-fetch port and one data port from the datapath and serialises them onto one fixed-latency RAM port. It returns `ihit`/`dhit` completion pulses with load data. It sits between the request unit/datapath and the unified RAM, and data requests take priority over instruction fetches.

---
 rtl/memory_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// Single-port memory arbiter: serialises an instruction-fetch port and a data port onto one
// fixed-latency RAM port, data first. Optional hit counters are enabled with MEMARB_PERF_EN.
module memory_arbiter #(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload
`ifdef MEMARB_PERF_EN
  ,
  output logic [31:0] icount,
  output logic [31:0] dcount
`endif
);

  localparam logic [3:0] CntInit = 4'(LAT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDacc,
    StIacc
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        kind_q, kind_d;  // 1: write
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic        ram_ren_q, ram_ren_d;
  logic        ram_wen_q, ram_wen_d;
  logic [31:0] iload_q, iload_d;
  logic [31:0] dload_q, dload_d;

  // Hits decode from registered state only; the last access cycle is the one with cnt at zero.
  assign ihit = (state_q == StIacc) && (cnt_q == 4'd0);
  assign dhit = (state_q == StDacc) && (cnt_q == 4'd0);

  assign iload = ihit ? ramload : iload_q;
  assign dload = (dhit && !kind_q) ? ramload : dload_q;

  assign ramREN   = ram_ren_q;
  assign ramWEN   = ram_wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    addr_d    = addr_q;
    store_d   = store_q;
    ram_ren_d = 1'b0;
    ram_wen_d = 1'b0;
    iload_d   = iload;
    dload_d   = dload;

    unique case (state_q)
      StIdle: begin
        if (dWEN || dREN) begin
          state_d   = StDacc;
          kind_d    = dWEN;
          addr_d    = daddr;
          store_d   = dstore;
          cnt_d     = CntInit;
          ram_ren_d = !dWEN;
          ram_wen_d = dWEN;
        end else if (iREN) begin
          state_d   = StIacc;
          kind_d    = 1'b0;
          addr_d    = iaddr;
          cnt_d     = CntInit;
          ram_ren_d = 1'b1;
        end
      end
      StDacc, StIacc: begin
        // No re-arbitration on completion: requesters drop their levels only after the hit.
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d     = cnt_q - 4'd1;
          ram_ren_d = ram_ren_q;
          ram_wen_d = ram_wen_q;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      kind_q    <= 1'b0;
      addr_q    <= 32'd0;
      store_q   <= 32'd0;
      ram_ren_q <= 1'b0;
      ram_wen_q <= 1'b0;
      iload_q   <= 32'd0;
      dload_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kind_q    <= kind_d;
      addr_q    <= addr_d;
      store_q   <= store_d;
      ram_ren_q <= ram_ren_d;
      ram_wen_q <= ram_wen_d;
      iload_q   <= iload_d;
      dload_q   <= dload_d;
    end
  end

`ifdef MEMARB_PERF_EN
  logic [31:0] icount_q, icount_d;
  logic [31:0] dcount_q, dcount_d;

  // Saturating hit counters.
  always_comb begin
    icount_d = icount_q;
    dcount_d = dcount_q;
    if (ihit && (icount_q != 32'hFFFF_FFFF)) begin
      icount_d = icount_q + 32'd1;
    end
    if (dhit && (dcount_q != 32'hFFFF_FFFF)) begin
      dcount_d = dcount_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icount_q <= 32'd0;
      dcount_q <= 32'd0;
    end else begin
      icount_q <= icount_d;
      dcount_q <= dcount_d;
    end
  end

  assign icount = icount_q;
  assign dcount = dcount_q;
`endif

endmodule
